ss_xfer_fifo: RTL and testbench

- Staging buffer and flow controller between the source (read) scatter-gather engine and the destination (write) scatter-gather engine of one ADMA channel.
- Captures 64-bit beats acknowledged by the read engine and presents them, show-ahead, to the write engine.
- Drives each engine's start/stop/end handshake from FIFO occupancy and job progress.

---
 rtl/ss_xfer_fifo.sv | 138 +++++++++++++
 tb/tb_ss_xfer_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ss_xfer_fifo.sv
// Show-ahead 32x64 staging FIFO between the read and write SG engines of one ADMA channel,
// with start/stop/end handshakes decoded from registered state and occupancy (one-cycle push-to-head).
module ss_xfer_fifo #(
    parameter int AW    = 5,
    parameter int BURST = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          job_go,
    input  logic          ss_done,
    input  logic [63:0]   src_dat,
    input  logic          src_xfer,
    input  logic          src_last,
    output logic          src_start,
    output logic          src_stop,
    output logic          src_end,
    output logic [63:0]   dst_dat,
    input  logic          dst_xfer,
    output logic          dst_start,
    output logic          dst_stop,
    output logic          dst_end,
    output logic [AW:0]   fifo_cnt,
    output logic          busy,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_C = (AW+1)'(BURST);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [63:0]     mem [DEPTH];

    logic active, empty, full, push_req, push, pop, ovf_hit, udf_hit;

    always_comb begin
        active   = (state_q == RUN) || (state_q == DRAIN);
        empty    = (cnt_q == '0);
        full     = (cnt_q == DEPTH_C);
        push_req = active && src_xfer && !src_last;
        pop      = active && dst_xfer && !empty;
        // A full FIFO still takes a beat when the same cycle frees a slot.
        push     = push_req && (!full || pop);
        ovf_hit  = push_req && full && !pop;
        udf_hit  = active && dst_xfer && empty;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW+1)'(1);
        ovf_d    = ovf_q || ovf_hit;
        udf_d    = udf_q || udf_hit;

        case (state_q)
            IDLE: begin
                if (job_go) begin
                    state_d  = RUN;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    udf_d    = 1'b0;
                end
            end
            RUN: begin
                if (ovf_hit || udf_hit)
                    state_d = ERR;
                else if (src_xfer && src_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (ovf_hit || udf_hit)
                    state_d = ERR;
                else if (empty && !push)
                    state_d = DONE;
            end
            DONE, ERR: begin
                if (ss_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr_q] <= src_dat;
    end

    // Stop flags are gated by state so that an idle or reset channel shows all-zero handshakes.
    always_comb begin
        src_start = (state_q == RUN) && ((DEPTH_C - cnt_q) >= BURST_C);
        src_stop  = active && (cnt_q >= DEPTH_C - (AW+1)'(1));
        dst_start = ((state_q == RUN) && (cnt_q >= BURST_C)) ||
                    ((state_q == DRAIN) && !empty);
        dst_stop  = active && (cnt_q <= (AW+1)'(1));
        src_end   = (state_q == DONE) || (state_q == ERR);
        dst_end   = src_end;
        dst_dat   = empty ? '0 : mem[rd_ptr_q];
        fifo_cnt  = cnt_q;
        busy      = (state_q != IDLE);
        ovf_err   = ovf_q;
        udf_err   = udf_q;
    end

endmodule

// File: tb/tb_ss_xfer_fifo.sv
// Directed bench for ss_xfer_fifo: normal job, full/overflow, drain, underflow and async reset.
module tb_ss_xfer_fifo;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        job_go   = 1'b0;
    logic        ss_done  = 1'b0;
    logic [63:0] src_dat  = '0;
    logic        src_xfer = 1'b0;
    logic        src_last = 1'b0;
    logic        dst_xfer = 1'b0;
    logic        src_start, src_stop, src_end, dst_start, dst_stop, dst_end;
    logic [63:0] dst_dat;
    logic [5:0]  fifo_cnt;
    logic        busy, ovf_err, udf_err;

    int nvec  = 0;
    int nfail = 0;

    localparam logic [63:0] BASE1 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] BASE2 = 64'h0000_0002_0000_0000;
    localparam logic [63:0] BASE3 = 64'h0000_0003_0000_0000;

    ss_xfer_fifo #(.AW(5), .BURST(8)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .job_go   (job_go),
        .ss_done  (ss_done),
        .src_dat  (src_dat),
        .src_xfer (src_xfer),
        .src_last (src_last),
        .src_start(src_start),
        .src_stop (src_stop),
        .src_end  (src_end),
        .dst_dat  (dst_dat),
        .dst_xfer (dst_xfer),
        .dst_start(dst_start),
        .dst_stop (dst_stop),
        .dst_end  (dst_end),
        .fifo_cnt (fifo_cnt),
        .busy     (busy),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".hs"}, {58'd0, src_start, src_stop, src_end, dst_start, dst_stop, dst_end}, 64'd0);
        chk({tag, ".cnt"}, {58'd0, fifo_cnt}, 64'd0);
        chk({tag, ".flags"}, {61'd0, busy, ovf_err, udf_err}, 64'd0);
        chk({tag, ".dat"}, dst_dat, 64'd0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        tick();
        wb_rst_i = 1'b0;
        tick();

        // Normal job: 8 pushes then 8 pops.
        job_go = 1'b1; tick(); job_go = 1'b0;
        chk("go.busy", {63'd0, busy}, 64'd1);
        chk("go.src_start", {63'd0, src_start}, 64'd1);
        src_xfer = 1'b1;
        for (int i = 0; i < 8; i++) begin
            src_dat = BASE1 + 64'(i);
            tick();
        end
        src_xfer = 1'b0;
        chk("p8.cnt", {58'd0, fifo_cnt}, 64'd8);
        chk("p8.dst_start", {63'd0, dst_start}, 64'd1);
        chk("p8.src_start", {63'd0, src_start}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("pop.dat", dst_dat, BASE1 + 64'(i));
            dst_xfer = 1'b1;
            tick();
        end
        dst_xfer = 1'b0;
        chk("pop8.cnt", {58'd0, fifo_cnt}, 64'd0);
        chk("pop8.dst_stop", {63'd0, dst_stop}, 64'd1);
        chk("pop8.dst_start", {63'd0, dst_start}, 64'd0);

        // Fill to full, simultaneous push/pop at full, then overflow.
        src_xfer = 1'b1;
        for (int i = 0; i < 31; i++) begin
            src_dat = BASE2 + 64'(i);
            tick();
        end
        chk("p31.cnt", {58'd0, fifo_cnt}, 64'd31);
        chk("p31.src_stop", {63'd0, src_stop}, 64'd1);
        chk("p31.src_start", {63'd0, src_start}, 64'd0);
        src_dat = BASE2 + 64'd31;
        tick();
        chk("p32.cnt", {58'd0, fifo_cnt}, 64'd32);
        chk("p32.ovf", {63'd0, ovf_err}, 64'd0);
        chk("p32.head", dst_dat, BASE2);
        src_dat = BASE2 + 64'd32;
        dst_xfer = 1'b1;
        tick();
        dst_xfer = 1'b0;
        chk("pp.cnt", {58'd0, fifo_cnt}, 64'd32);
        chk("pp.ovf", {63'd0, ovf_err}, 64'd0);
        chk("pp.head", dst_dat, BASE2 + 64'd1);
        chk("pp.end", {62'd0, src_end, dst_end}, 64'd0);
        src_dat = BASE2 + 64'd33;
        tick();
        src_xfer = 1'b0;
        chk("ovf.flag", {63'd0, ovf_err}, 64'd1);
        chk("ovf.end", {62'd0, src_end, dst_end}, 64'd3);
        chk("ovf.cnt", {58'd0, fifo_cnt}, 64'd32);
        ss_done = 1'b1; tick(); ss_done = 1'b0;
        chk("ovf.idle", {63'd0, busy}, 64'd0);
        chk("ovf.sticky", {63'd0, ovf_err}, 64'd1);

        // Drain path: 3 beats, end marker, 3 pops.
        job_go = 1'b1; tick(); job_go = 1'b0;
        chk("go2.clr", {62'd0, ovf_err, udf_err}, 64'd0);
        chk("go2.cnt", {58'd0, fifo_cnt}, 64'd0);
        src_xfer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_dat = BASE3 + 64'(i);
            tick();
        end
        src_last = 1'b1; src_dat = 64'hDEAD_BEEF;
        tick();
        src_xfer = 1'b0; src_last = 1'b0;
        chk("drain.cnt", {58'd0, fifo_cnt}, 64'd3);
        chk("drain.dst_start", {63'd0, dst_start}, 64'd1);
        chk("drain.src_start", {63'd0, src_start}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("drain.dat", dst_dat, BASE3 + 64'(i));
            dst_xfer = 1'b1;
            tick();
        end
        dst_xfer = 1'b0;
        chk("drain.empty_end", {62'd0, src_end, dst_end}, 64'd0);
        tick();
        chk("done.end", {62'd0, src_end, dst_end}, 64'd3);
        chk("done.busy", {63'd0, busy}, 64'd1);
        ss_done = 1'b1; tick(); ss_done = 1'b0;
        chk("done.idle", {63'd0, busy}, 64'd0);

        // Underflow, job_go ignored in ERR, flags clear on next job_go.
        job_go = 1'b1; tick(); job_go = 1'b0;
        dst_xfer = 1'b1; tick(); dst_xfer = 1'b0;
        chk("udf.flag", {62'd0, ovf_err, udf_err}, 64'd1);
        chk("udf.end", {62'd0, src_end, dst_end}, 64'd3);
        job_go = 1'b1; tick(); job_go = 1'b0;
        chk("udf.go_ignored", {62'd0, src_end, udf_err}, 64'd3);
        ss_done = 1'b1; tick(); ss_done = 1'b0;
        chk("udf.idle", {62'd0, busy, udf_err}, 64'd1);
        dst_xfer = 1'b1; tick(); dst_xfer = 1'b0;
        chk("idle.ignore_dst", {61'd0, busy, ovf_err, udf_err}, 64'd1);
        job_go = 1'b1; tick(); job_go = 1'b0;
        chk("go3.flags", {61'd0, busy, ovf_err, udf_err}, 64'd4);

        // Async reset mid-burst at cnt = 12.
        src_xfer = 1'b1;
        for (int i = 0; i < 12; i++) begin
            src_dat = BASE1 + 64'(i);
            tick();
        end
        chk("pre_rst.cnt", {58'd0, fifo_cnt}, 64'd12);
        #2 wb_rst_i = 1'b1;
        #1;
        chk_all_zero("arst");
        tick();
        wb_rst_i = 1'b0;
        tick();
        src_xfer = 1'b0;
        chk("post_rst.idle", {58'd0, fifo_cnt}, 64'd0);
        chk("post_rst.busy", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
